pc_sequencer: RTL

Program-counter sequencer for the single-cycle core. Each cycle it selects the next PC from one of four sources:
- sequential increment
- an absolute target fetched from the jump lookup table (JLUT): it drives a 5-bit table index and receives a 12-bit target combinationally
- a return-address stack (RAS)
- a start address

It also owns run/halt/fault status and the start/done handshake with the testbench/top level.

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC from increment, jump table, return stack or start
// address, and owns the run/done/fault status of the core.
module pc_sequencer #(
   parameter int PC_W      = 12,
   parameter int JP_W      = 5,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         Start,
   input  logic [PC_W-1:0]              StartAddr,
   input  logic [2:0]                   Op,
   input  logic                         Cond,
   input  logic [JP_W-1:0]              JptrIn,
   input  logic                         Stall,
   output logic [JP_W-1:0]              Jptr,
   input  logic [PC_W-1:0]              Jump,
   output logic [PC_W-1:0]              ProgCtr,
   output logic                         Busy,
   output logic                         Done,
   output logic                         Fault,
   output logic [$clog2(RAS_DEPTH):0]   RasLevel
);

   localparam int AW = $clog2(RAS_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BRC  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DONE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [PC_W-1:0]   w_pc_inc;
   logic [LW-1:0]     r_sp;
   logic [LW-1:0]     w_sp_nxt;
   logic [PC_W-1:0]   r_ras [RAS_DEPTH];
   logic              w_push;
   logic [AW-1:0]     w_top_idx;
   logic              w_full;
   logic              w_empty;

   // Increment wraps naturally at the PC width; rollover is not an error.
   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_top_idx = r_sp[AW-1:0] - AW'(1);
   assign w_full    = (r_sp == LW'(RAS_DEPTH));
   assign w_empty   = (r_sp == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_sp    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_sp    <= w_sp_nxt;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      end else if (w_push) begin
         r_ras[r_sp[AW-1:0]] <= w_pc_inc;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_sp_nxt    = r_sp;
      w_push      = 1'b0;
      case (r_state)
         S_RUN: begin
            // Stall freezes everything, HALT included; Start is ignored while running.
            if (!Stall) begin
               case (Op)
                  OP_JMP: w_pc_nxt = Jump;
                  OP_BRC: w_pc_nxt = Cond ? Jump : w_pc_inc;
                  OP_CALL: begin
                     if (w_full) begin
                        w_state_nxt = S_FAULT;
                     end else begin
                        w_push   = 1'b1;
                        w_sp_nxt = r_sp + LW'(1);
                        w_pc_nxt = Jump;
                     end
                  end
                  OP_RET: begin
                     if (w_empty) begin
                        w_state_nxt = S_FAULT;
                     end else begin
                        w_sp_nxt = r_sp - LW'(1);
                        w_pc_nxt = r_ras[w_top_idx];
                     end
                  end
                  OP_HALT: w_state_nxt = S_DONE;
                  default: w_pc_nxt = w_pc_inc;
               endcase
            end
         end
         default: begin
            if (Start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = StartAddr;
               w_sp_nxt    = '0;
            end
         end
      endcase
   end

   assign Jptr     = JptrIn;
   assign ProgCtr  = r_pc;
   assign RasLevel = r_sp;
   assign Busy     = (r_state == S_RUN);
   assign Done     = (r_state == S_DONE);
   assign Fault    = (r_state == S_FAULT);

endmodule
